// File: rtl/ov7670_sccb_config.sv
// ===========================================================================
// ov7670_sccb_config : walks a ROM register table and issues one SCCB write
// per entry to configure the OV7670 sensor.                Rev 1.0
// ===========================================================================
`default_nettype none

module ov7670_sccb_config #(
  parameter logic [7:0] DEV_ID       = 8'h42,
  parameter int         QTR_CYCLES   = 60,
  parameter int         DELAY_CYCLES = 240000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        sioc,
  output logic        siod_oe,
  output logic        busy,
  output logic        done
);

  localparam int QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QTR_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DELAY_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_BIT   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DELAY = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic          fetch_q, fetch_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [QW-1:0] cyc_q, cyc_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [26:0]   shift_q, shift_d;
  logic [7:0]    addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sioc_q, sioc_d;
  logic          oe_q, oe_d;
  logic          qtr_end;
  logic          advance;

  assign qtr_end = (cyc_q == Q_LAST);

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    qtr_d   = qtr_q;
    cyc_d   = cyc_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    advance = 1'b0;

    if (state_q inside {S_START, S_BIT, S_STOP, S_GAP})
      cyc_d = qtr_end ? '0 : cyc_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          fetch_d = 1'b0;
          addr_d  = 8'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_FETCH: begin
        // First cycle only covers the ROM read latency
        if (!fetch_q) begin
          fetch_d = 1'b1;
        end else if (tbl_data == 16'hFFFF) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tbl_data == 16'hFFF0) begin
          state_d = S_DELAY;
          dcnt_d  = '0;
        end else begin
          state_d = S_START;
          shift_d = {DEV_ID, 1'b1, tbl_data[15:8], 1'b1, tbl_data[7:0], 1'b1};
          qtr_d   = 2'd0;
          cyc_d   = '0;
        end
      end
      S_START: begin
        if (qtr_end) begin
          if (qtr_q == 2'd1) begin
            state_d = S_BIT;
            qtr_d   = 2'd0;
            bcnt_d  = 5'd0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      S_BIT: begin
        if (qtr_end) begin
          if (qtr_q == 2'd3) begin
            qtr_d = 2'd0;
            if (bcnt_q == 5'd26) begin
              state_d = S_STOP;
            end else begin
              bcnt_d  = bcnt_q + 5'd1;
              shift_d = {shift_q[25:0], 1'b0};
            end
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      S_STOP: begin
        if (qtr_end) begin
          if (qtr_q == 2'd2) begin
            state_d = S_GAP;
            qtr_d   = 2'd0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      S_GAP: begin
        if (qtr_end) begin
          if (qtr_q == 2'd3) advance = 1'b1;
          else               qtr_d   = qtr_q + 2'd1;
        end
      end
      S_DELAY: begin
        if (dcnt_q == D_LAST) advance = 1'b1;
        else                  dcnt_d  = dcnt_q + 1'b1;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Table never wraps: the last address ends the run
    if (advance) begin
      if (addr_q == 8'hFF) begin
        state_d = S_FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_FETCH;
        fetch_d = 1'b0;
        addr_d  = addr_q + 8'd1;
      end
    end
  end

  // Pin levels decoded from the upcoming state so the outputs stay registered
  always_comb begin
    sioc_d = 1'b1;
    oe_d   = 1'b0;
    case (state_d)
      S_START: begin
        oe_d   = 1'b1;
        sioc_d = (qtr_d == 2'd0);
      end
      S_BIT: begin
        sioc_d = qtr_d[1];
        oe_d   = ~shift_d[26];
      end
      S_STOP: begin
        sioc_d = (qtr_d != 2'd0);
        oe_d   = (qtr_d != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      fetch_q <= 1'b0;
      qtr_q   <= 2'd0;
      cyc_q   <= '0;
      bcnt_q  <= 5'd0;
      dcnt_q  <= '0;
      shift_q <= '0;
      addr_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sioc_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      qtr_q   <= qtr_d;
      cyc_q   <= cyc_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sioc_q  <= sioc_d;
      oe_q    <= oe_d;
    end
  end

  assign tbl_addr = addr_q;
  assign sioc     = sioc_q;
  assign siod_oe  = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: doc/ov7670_sccb_config.md
# ov7670_sccb_config

Power-up configuration sequencer for the OV7670 camera. On `start` it walks a register table held in a synchronous ROM. Each entry becomes one SCCB 3-phase write (device ID, sub-address, data) on the camera's SIOC/SIOD pins. It sits beside the camera capture interface in the top level, runs in the 24 MHz camera clock domain, and raises `done` when the sensor is configured so capture can be enabled.

## Interface
Parameters:
- `DEV_ID`, 8'h42: SCCB write ID byte sent first in every transaction.
- `QTR_CYCLES`, 60: clk cycles per SCCB quarter-bit (24 MHz / 60 / 4 = 100 kHz). Must be ≥1.
- `DELAY_CYCLES`, 240000: wait length for a delay entry (10 ms at 24 MHz).

Ports:
- `clk`, in, 1: the single clock (24 MHz). Everything is on its rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle request to run the table. Honoured only when `busy`=0.
- `tbl_addr`, out, 8: ROM address.
- `tbl_data`, in, 16: ROM word, with [15:8] = sub-address and [7:0] = value. Valid one cycle after `tbl_addr` changes.
- `sioc`, out, 1: SCCB clock. Push-pull.
- `siod_oe`, out, 1: 1 = pull SIOD low, 0 = release (pulled high externally). The pin is `siod_oe ? 0 : Z`.
- `busy`, out, 1: high from the cycle after an accepted `start` until the sequence ends.
- `done`, out, 1: high once the table has completed. Held until the next accepted `start`.

## Operation
- Reset (`reset`=0 at a clock edge) has the following effects:
  - Sets the state to IDLE.
  - Sets `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0 and `tbl_addr`=0.
  - Clears all counters.
  - Applies mid-transaction too: the bus is released immediately, with no stop condition issued.
- States and transitions:
  - IDLE: on `start`, go to FETCH with `tbl_addr`=0, `busy`=1, `done`=0.
  - FETCH: waits 1 cycle for ROM latency, then samples `tbl_data` and branches:
    - 16'hFFFF (end marker): go to FIN.
    - 16'hFFF0 (delay marker): go to DELAY.
    - Anything else: load the shift register with {DEV_ID, 1'b1, sub, 1'b1, val, 1'b1} (27 bits, MSB first) and go to START.
  - START:
    - Quarter 0: `sioc`=1, `siod_oe`=1.
    - Quarter 1: `sioc`=0, `siod_oe`=1.
  - BIT: 27 bits, 4 quarters each.
    - Quarter 0: `sioc`=0 and `siod_oe` = ~bit.
    - Quarters 1–3: `siod_oe` holds. `sioc`=0 in quarter 1 and `sioc`=1 in quarters 2 and 3.
    - Every 9th bit is the don't-care/ACK slot and is sent as 1 (released). The camera's response is ignored; there is no error path.
  - STOP:
    - Quarter 0: `sioc`=0, `siod_oe`=1.
    - Quarter 1: `sioc`=1, `siod_oe`=1.
    - Quarter 2: `sioc`=1, `siod_oe`=0.
  - GAP: 4 quarters with the bus idle (`sioc`=1, `siod_oe`=0). Then advance, in this order of checks:
    - If `tbl_addr`==255, go to FIN (no wrap).
    - Otherwise increment `tbl_addr` and go to FETCH.
  - DELAY: hold the bus idle for `DELAY_CYCLES` cycles, then advance exactly as at the end of GAP.
  - FIN: `busy`=0, `done`=1, return to IDLE.
- `start` while `busy`=1 is ignored. `start` in the same cycle as active reset is ignored.
- A rerun after `done` restarts from `tbl_addr`=0.
- Counters:
  - The quarter counter counts 0..`QTR_CYCLES`-1.
  - The bit counter counts 0..26 (5 bits).
  - The delay counter is wide enough for `DELAY_CYCLES`.
- All outputs are registered.

## Timing
- `start` sampled at edge N gives `busy`=1 and `tbl_addr`=0 after edge N. Table data is sampled at edge N+2.
- The first `siod_oe` rise (start condition) follows at edge N+2.
- Per write entry: (2 + 108 + 3 + 4) × `QTR_CYCLES` + 2 fetch cycles = 117×`QTR_CYCLES` + 2. At defaults this is 7022 cycles.
- Per delay entry: `DELAY_CYCLES` + 2 cycles.
- End marker: `done` rises 2 cycles after its address is presented.
- SIOD changes only while `sioc`=0, except the start and stop edges, which occur with `sioc`=1.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles, pulsing `start` during it → `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, `tbl_addr`=0, and no activity after release.
- **Single write:** `QTR_CYCLES`=2, table {16'h1280, FFFF}, then `start` → SCCB monitor decodes ID 0x42, sub 0x12, data 0x80 with three released ACK slots. `done`=1 exactly 117×2+2+2 cycles after `busy` rises.
- **Delay entry:** `DELAY_CYCLES`=50, table {FFF0, 1101, FFFF} → no SIOC toggles for 50 cycles, then one write of 0x11 ← 0x01, then `done`.
- **Table end without marker:** all 256 entries are writes → 256 transactions, `tbl_addr` stops at 255 (no wrap), `done`=1.
- **Reset mid-transaction:** assert `reset`=0 during bit 10 → the next cycle shows `sioc`=1, `siod_oe`=0, `busy`=0. A subsequent `start` replays from address 0.
- **Start while busy:** pulse `start` mid-sequence → no restart and `tbl_addr` continues monotonically. `start` after `done` clears `done` and reruns the table.
